matrix_key_responder: RTL and testbench

- Behavioural "far end" of the 4x4 matrix keypad: models the physical keypad the keyboard scanner talks to.
- Receives column drive on scan_out and returns row sense on scan_in, exactly as real contacts would.
- Accepts scripted press requests over a valid/ready handshake, holds each key closed for a programmed time, then releases it and enforces a gap.
- Used in bench and on-board self-test to exercise the scanner and the counting logic without a human operator.

---
 rtl/matrix_key_responder.sv | 169 ++++++++++++++++
 tb/tb_matrix_key_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_key_responder.sv
// Behavioural 4x4 keypad contact model: scripted presses with hold, release and gap timing.
// Optional contact bounce (LFSR-driven) is compiled in when KEY_BOUNCE_EN is defined.
module matrix_key_responder #(
  parameter int unsigned HOLD_W        = 16,
  parameter int unsigned BOUNCE_CYCLES = 200,
  parameter int unsigned GAP_CYCLES    = 1000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] req_hold,
  input  logic [3:0]        scan_out,
  output logic [3:0]        scan_in,
  output logic              busy,
  output logic              key_closed,
  output logic              done
);

  localparam longint unsigned HoldSpan = longint'(1) << HOLD_W;
  localparam longint unsigned MaxBg    = (BOUNCE_CYCLES > GAP_CYCLES) ?
                                         longint'(BOUNCE_CYCLES) : longint'(GAP_CYCLES);
  localparam longint unsigned MaxCnt   = (MaxBg > HoldSpan) ? MaxBg : HoldSpan;
  localparam int unsigned     CntW     = $clog2(MaxCnt) + 1;

  localparam logic [CntW-1:0] GapLd = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StBounceIn,
    StHold,
    StBounceOut,
    StGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      key_q;
  logic [CntW-1:0] hold_eff;

  // A zero hold request still closes the contact for one cycle.
  assign hold_eff  = (req_hold == '0) ? CntOne : CntW'(req_hold);
  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_comb begin
    scan_in = 4'b1111;
    if (key_closed && !scan_out[key_q[1:0]]) begin
      scan_in[key_q[3:2]] = 1'b0;
    end
  end

`ifdef KEY_BOUNCE_EN
  localparam logic [CntW-1:0] BounceLd = CntW'(BOUNCE_CYCLES);

  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_d;
  logic [CntW-1:0] hold_q;

  // Fibonacci x^8+x^6+x^5+x^4+1; key_closed takes the bit the LFSR is about to hold.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      key_q      <= '0;
      key_closed <= 1'b0;
      done       <= 1'b0;
`ifdef KEY_BOUNCE_EN
      hold_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            key_q <= req_key;
`ifdef KEY_BOUNCE_EN
            hold_q <= hold_eff;
            if (BOUNCE_CYCLES != 0) begin
              state_q    <= StBounceIn;
              cnt_q      <= BounceLd;
              key_closed <= lfsr_d[0];
            end else begin
              state_q    <= StHold;
              cnt_q      <= hold_eff;
              key_closed <= 1'b1;
            end
`else
            state_q    <= StHold;
            cnt_q      <= hold_eff;
            key_closed <= 1'b1;
`endif
          end
        end
`ifdef KEY_BOUNCE_EN
        StBounceIn: begin
          if (cnt_q == CntOne) begin
            state_q    <= StHold;
            cnt_q      <= hold_q;
            key_closed <= 1'b1;
          end else begin
            cnt_q      <= cnt_q - CntOne;
            key_closed <= lfsr_d[0];
          end
        end
        StBounceOut: begin
          if (cnt_q != CntOne) begin
            cnt_q      <= cnt_q - CntOne;
            key_closed <= lfsr_d[0];
          end else if (GAP_CYCLES != 0) begin
            state_q    <= StGap;
            cnt_q      <= GapLd;
            key_closed <= 1'b0;
          end else begin
            state_q    <= StIdle;
            key_closed <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        StHold: begin
          if (cnt_q != CntOne) begin
            cnt_q <= cnt_q - CntOne;
`ifdef KEY_BOUNCE_EN
          end else if (BOUNCE_CYCLES != 0) begin
            state_q    <= StBounceOut;
            cnt_q      <= BounceLd;
            key_closed <= lfsr_d[0];
`endif
          end else if (GAP_CYCLES != 0) begin
            state_q    <= StGap;
            cnt_q      <= GapLd;
            key_closed <= 1'b0;
          end else begin
            state_q    <= StIdle;
            key_closed <= 1'b0;
            done       <= 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == CntOne) begin
            state_q <= StIdle;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: begin
          state_q    <= StIdle;
          key_closed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_key_responder.sv
// Directed bench for matrix_key_responder (BOUNCE_CYCLES=8, GAP_CYCLES=10, HOLD_W=16).
// Works with or without KEY_BOUNCE_EN; bounce windows are checked against a reference LFSR.
module tb_matrix_key_responder;

  localparam int unsigned HW = 16;
  localparam int unsigned BC = 8;
  localparam int unsigned GC = 10;
`ifdef KEY_BOUNCE_EN
  localparam int BOFF = BC;
`else
  localparam int BOFF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_key = 4'd0;
  logic [HW-1:0] req_hold = '0;
  logic [3:0]    scan_out = 4'hF;
  logic          req_ready;
  logic [3:0]    scan_in;
  logic          busy;
  logic          key_closed;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matrix_key_responder #(
    .HOLD_W       (HW),
    .BOUNCE_CYCLES(BC),
    .GAP_CYCLES   (GC)
  ) dut (
    .clk_in    (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_hold  (req_hold),
    .scan_out  (scan_out),
    .scan_in   (scan_in),
    .busy      (busy),
    .key_closed(key_closed),
    .done      (done)
  );

  // Reference LFSR: seed A5, taps x^8+x^6+x^5+x^4+1, shifts every cycle out of reset.
  logic [7:0] ref_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) ref_lfsr <= 8'hA5;
    else      ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
  end

  typedef struct {
    logic [3:0] so;
    logic [3:0] exp_si;
  } idle_vec_t;

  typedef struct {
    logic [3:0]    key;
    logic [HW-1:0] hold;
    logic [3:0]    so;
    int            nhold;
    logic [3:0]    hold_si;
  } press_vec_t;

  idle_vec_t  idle_tbl[16];
  press_vec_t press_tbl[7];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  // Expected contact state in cycle k after the transfer edge (k=1 is the first).
  function automatic logic kc_model(input int k, input int nh);
    if (k < 1)                 return 1'b0;
    if (k <= BOFF)             return ref_lfsr[0];
    if (k <= BOFF + nh)        return 1'b1;
    if (k <= 2 * BOFF + nh)    return ref_lfsr[0];
    return 1'b0;
  endfunction

  task automatic run_press(input press_vec_t v);
    int   total;
    logic kc;
    total     = 2 * BOFF + v.nhold + GC;
    scan_out  = v.so;
    req_key   = v.key;
    req_hold  = v.hold;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      kc = kc_model(k, v.nhold);
      check("key_closed", k, {31'd0, key_closed}, {31'd0, kc});
      check("scan_in", k, {28'd0, scan_in}, {28'd0, (kc ? v.hold_si : 4'hF)});
      check("busy", k, {31'd0, busy}, {31'd0, (k <= total)});
      check("done", k, {31'd0, done}, {31'd0, (k == total + 1)});
      check("req_ready", k, {31'd0, req_ready}, {31'd0, (k > total)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   total;
    int   dones;
    bit   found;
    logic kc;

    for (int i = 0; i < 16; i++) begin
      idle_tbl[i].so     = 4'(i);
      idle_tbl[i].exp_si = 4'hF;
    end
    press_tbl[0] = '{key: 4'd6,  hold: 16'd20, so: 4'b1011, nhold: 20, hold_si: 4'b1101};
    press_tbl[1] = '{key: 4'd6,  hold: 16'd20, so: 4'b0111, nhold: 20, hold_si: 4'b1111};
    press_tbl[2] = '{key: 4'd6,  hold: 16'd0,  so: 4'b1011, nhold: 1,  hold_si: 4'b1101};
    press_tbl[3] = '{key: 4'd9,  hold: 16'd3,  so: 4'b1101, nhold: 3,  hold_si: 4'b1011};
    press_tbl[4] = '{key: 4'd15, hold: 16'd4,  so: 4'b0000, nhold: 4,  hold_si: 4'b0111};
    press_tbl[5] = '{key: 4'd0,  hold: 16'd20, so: 4'b1110, nhold: 20, hold_si: 4'b1110};
    press_tbl[6] = '{key: 4'd12, hold: 16'd2,  so: 4'b1111, nhold: 2,  hold_si: 4'b1111};

    // Reset state while held in reset.
    #12;
    check("reset scan_in", 0, {28'd0, scan_in}, 32'hF);
    check("reset req_ready", 0, {31'd0, req_ready}, 32'd1);
    check("reset busy", 0, {31'd0, busy}, 32'd0);
    check("reset done", 0, {31'd0, done}, 32'd0);
    check("reset key_closed", 0, {31'd0, key_closed}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (idle_tbl[i]) begin
      scan_out = idle_tbl[i].so;
      @(negedge clk);
      check("idle scan_in", i, {28'd0, scan_in}, {28'd0, idle_tbl[i].exp_si});
      check("idle req_ready", i, {31'd0, req_ready}, 32'd1);
      check("idle busy", i, {31'd0, busy}, 32'd0);
      check("idle done", i, {31'd0, done}, 32'd0);
    end

    foreach (press_tbl[i]) run_press(press_tbl[i]);

    // Requests while busy are ignored; a request held into the done cycle is taken at once.
    total     = 2 * BOFF + 20 + GC;
    scan_out  = 4'b1011;
    req_key   = 4'd6;
    req_hold  = 16'd20;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= total) check("busy req_ready", k, {31'd0, req_ready}, 32'd0);
      if (k >= BOFF + 2 && k <= BOFF + 20)
        check("latched key scan_in", k, {28'd0, scan_in}, 32'hD);
      if (k == total + 1) begin
        check("b2b done", k, {31'd0, done}, 32'd1);
        check("b2b req_ready", k, {31'd0, req_ready}, 32'd1);
        scan_out = 4'b0111;
      end
      if (k == 1) begin
        req_valid = 1'b1;
        req_key   = 4'd15;
        req_hold  = 16'd3;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    kc = kc_model(1, 3);
    check("b2b busy", 1, {31'd0, busy}, 32'd1);
    check("b2b key_closed", 1, {31'd0, key_closed}, {31'd0, kc});
    check("b2b scan_in", 1, {28'd0, scan_in}, {28'd0, (kc ? 4'b0111 : 4'hF)});
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b second done seen", 0, {31'd0, found}, 32'd1);

    // Reset in the 5th HOLD cycle aborts without a done pulse.
    scan_out  = 4'b1011;
    req_key   = 4'd6;
    req_hold  = 16'd20;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= BOFF + 5; k++) @(negedge clk);
    check("pre-abort scan_in", BOFF + 5, {28'd0, scan_in}, 32'hD);
    #1 rst = 1'b0;
    #1;
    check("abort scan_in", 0, {28'd0, scan_in}, 32'hF);
    check("abort busy", 0, {31'd0, busy}, 32'd0);
    check("abort key_closed", 0, {31'd0, key_closed}, 32'd0);
    check("abort done", 0, {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort done pulses", 0, dones, 32'd0);
    check("abort req_ready", 0, {31'd0, req_ready}, 32'd1);
    check("abort busy after", 0, {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
